// File: rtl/stdao2222_rr_arb.sv
// stdao2222_rr_arb: four-requester round-robin arbiter that drives the select legs
// (IN1, IN3, IN5, IN7) of a stdao2222 AND-OR path. At most one leg is ever high.
// Every owner change passes through one empty GAP cycle, so the AND-OR output
// never combines two sources. Every output comes straight from a flop, so there
// is no combinational path from REQ to GNT.
module stdao2222_rr_arb #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       NRESET,
  input  logic [3:0] REQ,
  input  logic       EN,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Last hold-count value before a contested owner has to give up the path.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;

  logic [1:0]       winner;
  logic             owner_req;
  logic             others_pending;
  logic             hold_expired;

  // Returns the first set request bit, searching upward from ptr and wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int off = 0; off < 4; off++) begin
      idx = ptr + 2'(off);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Evaluates the release conditions for the current owner.
  always_comb begin
    winner         = rr_pick(REQ, ptr_q);
    owner_req      = REQ[gnt_id_q];
    others_pending = |(REQ & ~gnt_q);
    hold_expired   = (hcnt_q == HOLD_LAST);
  end

  // Computes the next state, pointer, hold count and registered select legs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (EN && (REQ != 4'b0000)) begin
          gnt_d    = 4'b0001 << winner;
          gnt_id_d = winner;
          busy_d   = 1'b1;
          hcnt_d   = '0;
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!owner_req || (hold_expired && others_pending)) begin
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
          busy_d   = 1'b0;
          ptr_d    = gnt_id_q + 2'd1;
          hcnt_d   = '0;
          state_d  = ST_GAP;
        end else if (!hold_expired) begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
        busy_d   = 1'b0;
        hcnt_d   = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Holds the arbiter state. Reset clears every flop at once, so the select legs drop without waiting for a clock edge.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      hcnt_q   <= '0;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hcnt_q   <= hcnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

  assign GNT    = gnt_q;
  assign GNT_ID = gnt_id_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_stdao2222_rr_arb.sv
// Testbench for stdao2222_rr_arb: directed scenarios followed by random traffic,
// all checked against a cycle-level ownership model.
module tb_stdao2222_rr_arb;

  localparam int MAX_HOLD = 8;

  logic       CLK;
  logic       NRESET;
  logic [3:0] REQ;
  logic       EN;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;

  int assertCount = 0;
  int failCount   = 0;

  // Model: owner (-1 = none), cycles held so far, round-robin start point, and empty cycles still to wait.
  int mOwner = -1;
  int mHeld  = 0;
  int mPtr   = 0;
  int mCool  = 0;

  stdao2222_rr_arb #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .CLK    (CLK),
    .NRESET (NRESET),
    .REQ    (REQ),
    .EN     (EN),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY)
  );

  // Generates the free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mHeld  = 0;
    mPtr   = 0;
    mCool  = 0;
  endtask

  // Advances the ownership model by one clock edge.
  task automatic modelEdge(input logic [3:0] req, input logic en);
    logic [3:0] ownerMask;
    if (mOwner >= 0) begin
      ownerMask = 4'(1 << mOwner);
      if (!req[mOwner] || (mHeld >= MAX_HOLD && (req & ~ownerMask) != 4'b0)) begin
        mPtr   = (mOwner + 1) % 4;
        mOwner = -1;
        mCool  = 1;
      end else begin
        mHeld++;
      end
    end else if (mCool > 0) begin
      mCool--;
    end else if (en && req != 4'b0) begin
      for (int k = 0; k < 4; k++)
        if (mOwner < 0 && req[(mPtr + k) % 4]) mOwner = (mPtr + k) % 4;
      mHeld = 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] expGnt;
    logic [1:0] expId;
    expGnt = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
    expId  = (mOwner >= 0) ? 2'(mOwner) : 2'd0;
    checkEq({tag, ".gnt"},  32'(GNT),    32'(expGnt));
    checkEq({tag, ".id"},   32'(GNT_ID), 32'(expId));
    checkEq({tag, ".busy"}, 32'(BUSY),   32'(mOwner >= 0));
    checkEq({tag, ".onehot"}, 32'($countones(GNT) <= 1 && BUSY == |GNT), 32'd1);
  endtask

  // Drives one cycle of inputs, lets the edge happen, then checks 1 time unit later.
  task automatic applyStimulus(input logic [3:0] req, input logic en, input string tag);
    REQ = req;
    EN  = en;
    @(posedge CLK);
    modelEdge(req, en);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    NRESET = 1'b0;
    REQ    = 4'b0000;
    EN     = 1'b1;
    modelReset();
    #1;
    checkOutput("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    NRESET = 1'b1;
  endtask

  initial begin
    int zeroRun;
    int holdRun;
    int ownerSeq[$];
    int holdLens[$];
    int gapLens[$];
    logic [3:0] prevGnt;
    logic [3:0] rq;
    logic       en;

    NRESET = 1'b1;
    REQ    = 4'b0000;
    EN     = 1'b0;
    #2;

    // Reset and idle.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 1'b1, "idle");

    // Single requester held well past MAX_HOLD.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, "single.pre");
    applyStimulus(4'b0100, 1'b1, "single.first");
    checkEq("single.first_gnt", 32'(GNT), 32'h4);
    checkEq("single.first_id", 32'(GNT_ID), 32'd2);
    for (int i = 0; i < 19; i++) applyStimulus(4'b0100, 1'b1, "single.hold");
    checkEq("single.still_gnt", 32'(GNT), 32'h4);

    // Round robin with all four requesting.
    doReset();
    prevGnt = 4'b0000;
    zeroRun = 0;
    holdRun = 0;
    for (int i = 0; i < 52; i++) begin
      applyStimulus(4'b1111, 1'b1, "rr");
      if (GNT != 4'b0000) begin
        if (prevGnt == 4'b0000) begin
          ownerSeq.push_back(int'(GNT_ID));
          if (ownerSeq.size() > 1) gapLens.push_back(zeroRun);
          holdRun = 0;
        end
        holdRun++;
        zeroRun = 0;
      end else begin
        if (prevGnt != 4'b0000) holdLens.push_back(holdRun);
        zeroRun++;
      end
      prevGnt = GNT;
    end
    checkEq("rr.grant_count", 32'(ownerSeq.size() >= 5), 32'd1);
    if (ownerSeq.size() >= 5) begin
      for (int k = 0; k < 5; k++) checkEq("rr.owner_seq", 32'(ownerSeq[k]), 32'(k % 4));
    end
    checkEq("rr.hold_count", 32'(holdLens.size() >= 4), 32'd1);
    foreach (holdLens[k]) checkEq("rr.hold_len", 32'(holdLens[k]), 32'(MAX_HOLD));
    foreach (gapLens[k])  checkEq("rr.gap_len", 32'(gapLens[k]), 32'd2);

    // Early release by owner 1 with requesters 0 and 3 pending.
    doReset();
    applyStimulus(4'b0010, 1'b1, "early.grant");
    checkEq("early.owner1", 32'(GNT), 32'h2);
    applyStimulus(4'b1011, 1'b1, "early.hold");
    applyStimulus(4'b1011, 1'b1, "early.hold");
    applyStimulus(4'b1001, 1'b1, "early.rel");
    applyStimulus(4'b1001, 1'b1, "early.gap");
    checkEq("early.gap_zero", 32'(GNT), 32'h0);
    applyStimulus(4'b1001, 1'b1, "early.next");
    checkEq("early.next_owner3", 32'(GNT), 32'h8);

    // Wrap-around from owner 3 to owner 0.
    doReset();
    applyStimulus(4'b1000, 1'b1, "wrap.grant");
    applyStimulus(4'b1011, 1'b1, "wrap.hold");
    applyStimulus(4'b0011, 1'b1, "wrap.rel");
    applyStimulus(4'b0011, 1'b1, "wrap.gap");
    applyStimulus(4'b0011, 1'b1, "wrap.next");
    checkEq("wrap.owner0", 32'(GNT), 32'h1);

    // Enable gating.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 1'b0, "en.blocked");
    checkEq("en.blocked_gnt", 32'(GNT), 32'h0);
    applyStimulus(4'b0010, 1'b1, "en.rise");
    checkEq("en.rise_gnt", 32'(GNT), 32'h2);
    for (int i = 0; i < 12; i++) applyStimulus(4'b0010, 1'b0, "en.low_hold");
    checkEq("en.persist_gnt", 32'(GNT), 32'h2);
    applyStimulus(4'b0000, 1'b0, "en.drop");
    checkEq("en.drop_gnt", 32'(GNT), 32'h0);

    // Asynchronous reset in the middle of a grant.
    applyStimulus(4'b0000, 1'b1, "arst.gap");
    applyStimulus(4'b0001, 1'b1, "arst.idle");
    applyStimulus(4'b0001, 1'b1, "arst.grant");
    checkEq("arst.granted", 32'(GNT), 32'h1);
    NRESET = 1'b0;
    #2;
    modelReset();
    checkEq("arst.gnt_async", 32'(GNT), 32'h0);
    checkEq("arst.busy_async", 32'(BUSY), 32'h0);
    @(negedge CLK);
    NRESET = 1'b1;

    // Random traffic; requests change only now and then so hold expiry gets exercised.
    doReset();
    rq = 4'b0000;
    en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3, 0) == 0) rq = 4'($urandom_range(15, 0));
      if ($urandom_range(9, 0) == 0) en = ~en;
      applyStimulus(rq, en, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
